uart_tx_drain: RTL and testbench

- Downstream consumer of sync_fifo. It pops one byte at a time from the FIFO read port and serialises it as an asynchronous UART frame on a single TX line.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB first, no parity, STOP_BITS stop bits.
- Sits between the transmit FIFO and the board UART TX pin. It is the only agent driving the FIFO's r_en.

---
 rtl/uart_tx_drain.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_drain.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain
// Pops one word at a time from a sync_fifo read port and serialises it as an
// asynchronous UART frame: 1 start bit, DATA_WIDTH data bits LSB first,
// no parity, STOP_BITS stop bits. This block is the only reader of the FIFO.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tx_en       allows new frames to start; a frame in flight always completes
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after r_en is sampled
//   fifo_r_en   FIFO read strobe, one cycle per frame
//   tx          serial line, idle high
//   busy        high whenever the FSM is not IDLE
//   tx_done     one-cycle pulse in the first IDLE cycle after the last stop bit
//
// state | meaning
// IDLE  | line high, waiting for tx_en and a non-empty FIFO
// POP   | fifo_r_en high for this single cycle
// LOAD  | FIFO presents the popped word; captured on the exit edge
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bits (high) for STOP_BITS*CLKS_PER_BIT cycles
module uart_tx_drain #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // One index register serves both the data bits and the stop bits.
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  bit_end;

  assign shift_next = shift_reg >> 1;
  assign bit_end    = (baud_cnt == BAUD_LAST);

  // Decoded only from the state register, so no input reaches it combinationally.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      fifo_r_en <= 1'b0;
      tx_done   <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      fifo_r_en <= 1'b0;
      tx_done   <= 1'b0;

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (tx_en && !fifo_empty) begin
            state     <= POP;
            fifo_r_en <= 1'b1;
          end
        end

        POP: begin
          baud_cnt <= '0;
          state    <= LOAD;
        end

        // fifo_data is valid now because the FIFO sampled r_en on the POP exit edge.
        LOAD: begin
          shift_reg <= fifo_data;
          tx        <= 1'b0;
          baud_cnt  <= '0;
          state     <= START;
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // tx is registered, so on each bit boundary it takes the bit that
        // will sit in shift_reg[0] after this shift.
        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_next;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
`timescale 1ns/1ps
module tb_uart_tx_drain;

  localparam int CF = 100;
  localparam int BD = 10;
  localparam int C  = CF / BD;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic tx_en1, tx_en2;
  logic fifo_empty;
  logic [7:0] fifo_data;
  logic ren1, ren2, tx1, tx2, busy1, busy2, done1, done2;

  always #5 clk = ~clk;

  uart_tx_drain #(.CLK_FREQ(CF), .BAUD(BD), .DATA_WIDTH(DW), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en1), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(ren1), .tx(tx1), .busy(busy1), .tx_done(done1));

  uart_tx_drain #(.CLK_FREQ(CF), .BAUD(BD), .DATA_WIDTH(DW), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(ren2), .tx(tx2), .busy(busy2), .tx_done(done2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int   pops[2], dones[2], starts[2], last_pop[2], last_done[2], start_cyc[2];
  logic prev_ren[2];
  logic gap_chk = 1'b0;
  int   gap_arm = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic tx_of(input int w);   return (w == 0) ? tx1   : tx2;   endfunction
  function automatic logic busy_of(input int w); return (w == 0) ? busy1 : busy2; endfunction
  function automatic logic done_of(input int w); return (w == 0) ? done1 : done2; endfunction
  function automatic logic ren_of(input int w);  return (w == 0) ? ren1  : ren2;  endfunction

  // FIFO model: a strobe seen during POP hands the head word to fifo_data,
  // which stays put through LOAD. The popped word is what that DUT must send.
  always @(negedge clk) begin
    if (!rst && (ren1 || ren2)) begin
      check("pop_when_nonempty", int'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) begin
        fifo_data = fifo_q.pop_front();
        if (ren1) exp_q0.push_back(fifo_data);
        else      exp_q1.push_back(fifo_data);
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Strobe / pulse event counters and per-event rules.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        prev_ren[w] = 1'b0;
      end else begin
        if (ren_of(w)) begin
          check("ren_single_cycle", int'(prev_ren[w]), 0);
          check("ren_with_done", int'(done_of(w)), 0);
          pops[w]++;
          last_pop[w] = cyc;
        end
        if (done_of(w)) dones[w]++;
        prev_ren[w] = ren_of(w);
      end
    end
  end

  // Line monitor: on each falling edge, compares the whole frame waveform
  // (one expected level per clock) against the next popped byte.
  task automatic mon(input int w);
    logic       prev_tx;
    logic [7:0] b;
    logic       ebit, aborted, have;
    int         s, errs, first_bad, nb, pos;
    prev_tx = 1'b1;
    nb = 1 + DW + ((w == 0) ? 1 : 2);
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_tx = 1'b1;
        continue;
      end
      if (prev_tx && !tx_of(w)) begin
        s = cyc;
        starts[w]++;
        start_cyc[w] = s;
        have = (w == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        check($sformatf("frame_expected_dut%0d", w + 1), int'(have), 1);
        b = 8'h00;
        if (have) b = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("pop_to_start_dut%0d", w + 1), s - last_pop[w], 2);
        if (w == 0 && gap_chk && last_done[0] > gap_arm)
          check("interframe_gap", s - last_done[0], 3);
        errs = 0;
        first_bad = -1;
        aborted = 1'b0;
        for (int i = 0; i < nb * C; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          pos = i / C;
          if (pos == 0)       ebit = 1'b0;
          else if (pos <= DW) ebit = b[pos-1];
          else                ebit = 1'b1;
          if (tx_of(w) !== ebit || busy_of(w) !== 1'b1) begin
            errs++;
            if (first_bad < 0) first_bad = i;
          end
        end
        if (!aborted) begin
          check($sformatf("frame_dut%0d_byte%02h_firstbad%0d", w + 1, b, first_bad), errs, 0);
          @(negedge clk);
          if (!rst) begin
            check($sformatf("done_at_frame_end_dut%0d", w + 1), int'(done_of(w)), 1);
            check($sformatf("idle_after_frame_dut%0d", w + 1), int'(busy_of(w)), 0);
            last_done[w] = cyc;
          end
        end
        prev_tx = rst ? 1'b1 : tx_of(w);
      end else begin
        prev_tx = tx_of(w);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 5 && n < budget) begin
      @(negedge clk);
      n++;
      if (fifo_empty && !busy1 && !busy2 && !ren1 && !ren2) quiet++;
      else quiet = 0;
    end
    check({"drain_", name}, int'(quiet >= 5), 1);
  endtask

  task automatic wait_start(input int w, input int budget);
    int base = starts[w];
    int n = 0;
    while (starts[w] == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_started", int'(starts[w] != base), 1);
  endtask

  task automatic wait_until_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic reset_pulse_now();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tx_high", int'(tx1), 1);
    check("async_reset_not_busy", int'(busy1), 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int bp, bd, bs, bad_a, bad_b, bad_c, pushed;
    rst = 1'b1;
    tx_en1 = 1'b0;
    tx_en2 = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = 8'h00;
    for (int w = 0; w < 2; w++) begin
      pops[w] = 0; dones[w] = 0; starts[w] = 0;
      last_pop[w] = -1000000; last_done[w] = -1000000; start_cyc[w] = 0;
      prev_ren[w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx1), 1);
    check("reset_busy", int'(busy1), 0);
    check("reset_ren", int'(ren1), 0);
    check("reset_done", int'(done1), 0);
    check("reset_tx_dut2", int'(tx2), 1);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte
    bp = pops[0]; bd = dones[0]; bs = starts[0];
    tx_en1 = 1'b1;
    push_byte(8'hA5);
    wait_drain("single", 2000);
    check("t1_pops", pops[0] - bp, 1);
    check("t1_dones", dones[0] - bd, 1);
    check("t1_frames", starts[0] - bs, 1);

    // 2: back-to-back
    bp = pops[0]; bd = dones[0];
    gap_chk = 1'b1;
    gap_arm = cyc;
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h3C);
    wait_drain("b2b", 3000);
    gap_chk = 1'b0;
    check("t2_pops", pops[0] - bp, 3);
    check("t2_dones", dones[0] - bd, 3);
    bad_a = 0;
    repeat (20) begin
      @(negedge clk);
      if (!tx1 || busy1) bad_a++;
    end
    check("t2_stays_idle", bad_a, 0);

    // 3: two stop bits
    tx_en1 = 1'b0;
    bp = pops[1]; bd = dones[1];
    tx_en2 = 1'b1;
    push_byte(8'h81);
    wait_drain("stop2", 2000);
    tx_en2 = 1'b0;
    check("t3_pops", pops[1] - bp, 1);
    check("t3_dones", dones[1] - bd, 1);

    // 4: tx_en gating
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    bad_a = 0; bad_b = 0; bad_c = 0;
    repeat (50) begin
      @(negedge clk);
      if (ren1) bad_a++;
      if (!tx1) bad_b++;
      if (busy1) bad_c++;
    end
    check("t4_no_pop_when_disabled", bad_a, 0);
    check("t4_tx_high_when_disabled", bad_b, 0);
    check("t4_idle_when_disabled", bad_c, 0);
    bp = pops[0];
    tx_en1 = 1'b1;
    wait_start(0, 100);
    wait_until_cyc(start_cyc[0] + 44);
    tx_en1 = 1'b0;
    repeat (200) @(negedge clk);
    check("t4_one_pop_after_drop", pops[0] - bp, 1);
    check("t4_fifo_left", fifo_q.size(), 2);
    check("t4_idle_after_drop", int'(busy1), 0);
    tx_en1 = 1'b1;
    wait_drain("gating", 3000);

    // 5: reset mid-frame (data bit 4, then during a start bit)
    tx_en1 = 1'b0;
    push_byte(8'h55); push_byte(8'h66); push_byte(8'hC3);
    bd = dones[0];
    tx_en1 = 1'b1;
    wait_start(0, 100);
    wait_until_cyc(start_cyc[0] + 54);
    reset_pulse_now();
    wait_start(0, 100);
    wait_until_cyc(start_cyc[0] + 5);
    reset_pulse_now();
    wait_drain("after_reset", 2000);
    check("t5_dones", dones[0] - bd, 1);
    check("t5_scoreboard_empty", exp_q0.size(), 0);

    // randomized traffic with random tx_en toggling
    bp = pops[0]; bd = dones[0];
    pushed = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2 && pushed < 12) begin
        push_byte(8'($urandom));
        pushed++;
      end
      if ($urandom_range(0, 199) == 0) tx_en1 = ~tx_en1;
    end
    while (pushed < 12) begin
      push_byte(8'($urandom));
      pushed++;
    end
    tx_en1 = 1'b1;
    wait_drain("random", 5000);
    check("rand_pops", pops[0] - bp, 12);
    check("rand_dones", dones[0] - bd, 12);
    check("rand_scoreboard_empty", exp_q0.size(), 0);

    // 6: empty FIFO idle
    bad_a = 0; bad_b = 0; bad_c = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ren1) bad_a++;
      if (!tx1) bad_b++;
      if (done1) bad_c++;
    end
    check("t6_no_pop_empty", bad_a, 0);
    check("t6_tx_high_empty", bad_b, 0);
    check("t6_no_done_empty", bad_c, 0);
    check("dut2_scoreboard_empty", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
